seg_scan_ctrl: RTL and testbench

//  Multiplexed 4-digit 7-segment display controller for the real-time clock core.

---
 rtl/clock_pkg.sv | 48 ++++
 rtl/bin2bcd_2digit.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// ============================================================================
// clock_pkg : mode encodings and 7-segment font shared with the clock core
// Revision  : 1.0
// ============================================================================
`default_nettype none

package clock_pkg;

  typedef enum logic [2:0] {
    MODE_TIME       = 3'd0,
    MODE_EDIT_HOUR  = 3'd1,
    MODE_EDIT_MIN   = 3'd2,
    MODE_EDIT_MONTH = 3'd3,
    MODE_EDIT_DAY   = 3'd4
  } mode_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_font(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_2digit.sv
// ============================================================================
// bin2bcd_2digit : 6-bit binary to two BCD digits with range check
// Revision       : 1.0
// ============================================================================
`default_nettype none

module bin2bcd_2digit (
  input  logic [5:0] value,
  input  logic [5:0] lo,
  input  logic [5:0] hi,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       dash
);

  // Largest multiple of ten not exceeding the value; remainder always fits 4 bits.
  always_comb begin
    tens  = 4'd0;
    units = value[3:0];
    for (int t = 1; t <= 6; t++) begin
      if (value >= 6'(10 * t)) begin
        tens  = 4'(t);
        units = 4'(value - 6'(10 * t));
      end
    end
  end

  assign dash = (value < lo) || (value > hi);

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// seg_scan_ctrl : 4-digit multiplexed 7-segment scanner with edit-field blink
// Revision      : 1.0
// ============================================================================
`default_nettype none

module seg_scan_ctrl
  import clock_pkg::*;
#(
  parameter int SCAN_DIV     = 8,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_W      = 14,
  parameter int HOLD_CYCLES  = 16384
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] mode,
  input  logic       run,
  input  logic       edit_pulse,
  input  logic [4:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  input  logic [3:0] month,
  input  logic [4:0] day,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] dig_en
);

  localparam int                  HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0]   HOLD_INIT = HOLD_W'(HOLD_CYCLES);
  localparam logic [SCAN_DIV-1:0] BLANK_LIM = SCAN_DIV'(BLANK_CYCLES);

  logic [SCAN_DIV-1:0] slot_cnt, slot_nxt;
  logic [1:0]          idx, idx_nxt;
  logic [BLINK_W-1:0]  blink_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [2:0]          mode_q;
  logic [4:0]          snap_hour;
  logic [5:0]          snap_minute;
  logic [5:0]          snap_second;
  logic [3:0]          snap_month;
  logic [4:0]          snap_day;

  logic       slot_wrap, frame_wrap, slot_start;
  logic       is_date, edit_left, edit_right, blink_off;
  logic [5:0] left_val, right_val, left_lo, left_hi, right_lo, right_hi;
  logic [3:0] l_tens, l_units, r_tens, r_units;
  logic       l_dash, r_dash;
  logic [6:0] seg_d;
  logic       dp_d;
  logic       unused_sec;

  assign slot_wrap  = &slot_cnt;
  assign frame_wrap = slot_wrap && (idx == 2'd3);
  assign slot_start = (slot_cnt == '0);
  assign slot_nxt   = slot_cnt + SCAN_DIV'(1);
  assign idx_nxt    = slot_wrap ? idx + 2'd1 : idx;
  assign unused_sec = ^snap_second[5:1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_cnt  <= '0;
      idx       <= 2'd0;
      blink_cnt <= '0;
    end else begin
      slot_cnt  <= slot_nxt;
      idx       <= idx_nxt;
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // A pulse always reloads, even on the cycle the mode changes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
      mode_q   <= 3'd0;
    end else begin
      mode_q <= mode;
      if (edit_pulse)
        hold_cnt <= HOLD_INIT;
      else if (mode != mode_q)
        hold_cnt <= '0;
      else if (hold_cnt != '0)
        hold_cnt <= hold_cnt - HOLD_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snap_hour   <= '0;
      snap_minute <= '0;
      snap_second <= '0;
      snap_month  <= '0;
      snap_day    <= '0;
    end else if (frame_wrap) begin
      snap_hour   <= hour;
      snap_minute <= minute;
      snap_second <= second;
      snap_month  <= month;
      snap_day    <= day;
    end
  end

  assign is_date   = (mode == MODE_EDIT_MONTH) || (mode == MODE_EDIT_DAY);
  assign left_val  = is_date ? {2'b00, snap_month} : {1'b0, snap_hour};
  assign left_lo   = is_date ? 6'd1 : 6'd0;
  assign left_hi   = is_date ? 6'd12 : 6'd23;
  assign right_val = is_date ? {1'b0, snap_day} : snap_minute;
  assign right_lo  = is_date ? 6'd1 : 6'd0;
  assign right_hi  = is_date ? 6'd31 : 6'd59;

  bin2bcd_2digit u_left (
    .value (left_val),
    .lo    (left_lo),
    .hi    (left_hi),
    .tens  (l_tens),
    .units (l_units),
    .dash  (l_dash)
  );

  bin2bcd_2digit u_right (
    .value (right_val),
    .lo    (right_lo),
    .hi    (right_hi),
    .tens  (r_tens),
    .units (r_units),
    .dash  (r_dash)
  );

  assign edit_left  = (mode == MODE_EDIT_HOUR) || (mode == MODE_EDIT_MONTH);
  assign edit_right = (mode == MODE_EDIT_MIN) || (mode == MODE_EDIT_DAY);
  assign blink_off  = blink_cnt[BLINK_W-1] && (hold_cnt == '0);

  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    if (mode <= MODE_EDIT_DAY) begin
      case (idx)
        2'd3:    seg_d = l_dash ? SEG_DASH : seg_font(l_tens);
        2'd2:    seg_d = l_dash ? SEG_DASH : seg_font(l_units);
        2'd1:    seg_d = r_dash ? SEG_DASH : seg_font(r_tens);
        default: seg_d = r_dash ? SEG_DASH : seg_font(r_units);
      endcase
      if (blink_off && ((edit_left && idx[1]) || (edit_right && !idx[1])))
        seg_d = SEG_BLANK;
      if (idx == 2'd2)
        dp_d = (mode == MODE_TIME) ? (snap_second[0] & run) : 1'b1;
    end
  end

  // seg/dp latch only on the first cycle of a slot, well inside the blank window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg    <= SEG_BLANK;
      dp     <= 1'b0;
      dig_en <= 4'b0000;
    end else begin
      dig_en <= (slot_nxt < BLANK_LIM) ? 4'b0000 : (4'b0001 << idx_nxt);
      if (slot_start) begin
        seg <= seg_d;
        dp  <= dp_d;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// tb_seg_scan_ctrl : self-checking bench for seg_scan_ctrl
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] mode = 3'd0;
  logic       run = 1'b1;
  logic       edit_pulse = 1'b0;
  logic [4:0] hour = 5'd12;
  logic [5:0] minute = 6'd34;
  logic [5:0] second = 6'd0;
  logic [3:0] month = 4'd1;
  logic [4:0] day = 5'd1;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] dig_en;

  seg_scan_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .mode       (mode),
    .run        (run),
    .edit_pulse (edit_pulse),
    .hour       (hour),
    .minute     (minute),
    .second     (second),
    .month      (month),
    .day        (day),
    .seg        (seg),
    .dp         (dp),
    .dig_en     (dig_en)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: n = rising edges since reset release.
  int n;
  int s_hour, s_minute, s_second, s_month, s_day;
  int last_pulse;
  bit hold_valid;
  int prev_mode;
  int exp_seg, exp_dp;
  int font [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  function automatic int field_digit(input int v, input int lo, input int hi, input bit want_tens);
    if (v < lo || v > hi) return 'h40;
    return want_tens ? font[v / 10] : font[v % 10];
  endfunction

  task automatic model_reset();
    n = 0;
    s_hour = 0; s_minute = 0; s_second = 0; s_month = 0; s_day = 0;
    hold_valid = 0; last_pulse = 0; prev_mode = 0;
    exp_seg = 0; exp_dp = 0;
  endtask

  // Expected digit for the slot whose first cycle was edge n-1.
  task automatic predict();
    int pos, m, lv, rv, llo, lhi, rlo, rhi;
    bit blink;
    pos = ((n - 1) / 256) % 4;
    m = int'(mode);
    exp_seg = 0;
    exp_dp = 0;
    if (m <= 4) begin
      if (m >= 3) begin
        lv = s_month; llo = 1; lhi = 12; rv = s_day; rlo = 1; rhi = 31;
      end else begin
        lv = s_hour; llo = 0; lhi = 23; rv = s_minute; rlo = 0; rhi = 59;
      end
      case (pos)
        3: exp_seg = field_digit(lv, llo, lhi, 1);
        2: exp_seg = field_digit(lv, llo, lhi, 0);
        1: exp_seg = field_digit(rv, rlo, rhi, 1);
        default: exp_seg = field_digit(rv, rlo, rhi, 0);
      endcase
      blink = (((n - 1) / 8192) % 2 == 1) && !(hold_valid && (n - 1 - last_pulse) < 16384);
      if (blink && (((m == 1 || m == 3) && pos >= 2) || ((m == 2 || m == 4) && pos < 2)))
        exp_seg = 0;
      if (pos == 2) exp_dp = (m == 0) ? (s_second % 2) & int'(run) : 1;
    end
  endtask

  task automatic step();
    int off, pos;
    @(negedge clock);
    n++;
    if (n % 1024 == 0) begin
      s_hour = hour; s_minute = minute; s_second = second; s_month = month; s_day = day;
    end
    if (n % 256 == 1) predict();
    if (edit_pulse) begin
      last_pulse = n;
      hold_valid = 1;
    end else if (int'(mode) != prev_mode) begin
      hold_valid = 0;
    end
    prev_mode = int'(mode);
    off = n % 256;
    pos = (n / 256) % 4;
    if (off == 0 || off == 15 || off == 16 || off == 255)
      check("dig_en", 32'(dig_en), (off < 16) ? 0 : (1 << pos));
    if (off == 16 || off == 255) begin
      check("seg", 32'(seg), exp_seg);
      check("dp", 32'(dp), exp_dp);
    end
    edit_pulse = 1'b0;
  endtask

  task automatic run_cycles(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_dig_en", 32'(dig_en), 0);
    check("rst_seg", 32'(seg), 0);
    check("rst_dp", 32'(dp), 0);
    repeat (3) @(negedge clock);
    check("rst_hold_dig_en", 32'(dig_en), 0);
    check("rst_hold_seg", 32'(seg), 0);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();
    run_cycles(3 * 1024);
    second = 6'd1;
    run_cycles(2048);
    run = 1'b0;
    run_cycles(1024);
    run = 1'b1;

    for (int it = 0; it < 12; it++) begin
      run_cycles($urandom_range(100, 900));
      mode       = 3'($urandom_range(0, 7));
      run        = 1'($urandom_range(0, 1));
      hour       = 5'($urandom_range(0, 31));
      minute     = 6'($urandom_range(0, 63));
      second     = 6'($urandom_range(0, 63));
      month      = 4'($urandom_range(0, 15));
      day        = 5'($urandom_range(0, 31));
      edit_pulse = 1'($urandom_range(0, 1));
    end

    run_cycles(300);
    do_reset();
    run_cycles(2048);

    mode = 3'd1; hour = 5'd9; minute = 6'd45;
    run_cycles(20 * 1024);
    edit_pulse = 1'b1;
    run_cycles(20 * 1024);

    mode = 3'd3; month = 4'd0; day = 5'd31;
    run_cycles(3 * 1024);
    mode = 3'd4; month = 4'd12; day = 5'd0;
    run_cycles(2048);

    mode = 3'd2; minute = 6'd59;
    run_cycles(2048 + 500);
    minute = 6'd0;
    run_cycles(2048);

    mode = 3'd6;
    run_cycles(2048);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
